// File: rtl/issue_arbiter.sv
// Issue-queue arbiter: picks one ready entry per functional unit (FU0/FU1 ALU, FU2 LSU).
// Optional oldest-first selection via macro ISSUE_AGE_PRIORITY_EN; default build is lowest-index-first.
module issue_arbiter #(
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned FU_ARRAY = 3,
  parameter int unsigned LSU_LAT  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RS_SIZE-1:0]      req_valid_in,
  input  logic [2*RS_SIZE-1:0]    req_fu_in,
  input  logic                    alloc_valid_in,
  input  logic [3:0]              alloc_idx_in,
  input  logic [FU_ARRAY-1:0]     fu_ready_from_FU_in,
  input  logic                    flush_in,
  output logic [FU_ARRAY-1:0]     grant_valid_out,
  output logic [3:0]              grant_idx_out1,
  output logic [3:0]              grant_idx_out2,
  output logic [3:0]              grant_idx_out3,
  output logic [RS_SIZE-1:0]      grant_vec_out,
  output logic [FU_ARRAY-1:0]     fu_busy_out
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = $clog2(LSU_LAT + 1);
  localparam int unsigned LSU_FU = 2;

  logic [CNT_W-1:0]                  lsu_cnt_q;
  logic                              live_q;
  logic [RS_SIZE-1:0][RS_SIZE-1:0]   older;
  logic [FU_ARRAY-1:0][RS_SIZE-1:0]  cand;
  logic [FU_ARRAY-1:0]               win_valid;
  logic [FU_ARRAY-1:0][IDX_W-1:0]    win_idx;
  logic [RS_SIZE-1:0]                win_vec;

`ifdef ISSUE_AGE_PRIORITY_EN
  // age_q[i][j]=1: entry i was allocated before entry j
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q;
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age_d;

  always_comb begin
    age_d = age_q;
    if (alloc_valid_in) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        age_d[i][alloc_idx_in] = 1'b1;
      end
      age_d[alloc_idx_in] = '0;
    end
    if (flush_in) begin
      age_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  // older[i] lists the entries older than i (column i of the matrix)
  always_comb begin
    older = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      for (int unsigned j = 0; j < RS_SIZE; j++) begin
        older[i][j] = age_q[j][i];
      end
    end
  end
`else
  logic unused_alloc;
  assign unused_alloc = ^{alloc_valid_in, alloc_idx_in};

  always_comb begin
    older = '0;
  end
`endif

  // Blocks grants on the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  always_comb begin
    fu_busy_out         = '0;
    fu_busy_out[LSU_FU] = (lsu_cnt_q != '0);
  end

  always_comb begin
    cand = '0;
    for (int unsigned n = 0; n < FU_ARRAY; n++) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        cand[n][i] = live_q && req_valid_in[i] && (req_fu_in[2*i +: 2] == 2'(n)) &&
                     !grant_vec_out[i] && fu_ready_from_FU_in[n] && !fu_busy_out[n];
      end
    end
  end

  // A candidate wins when no other candidate is older; index order breaks ties
  always_comb begin
    win_valid = '0;
    win_idx   = '0;
    win_vec   = '0;
    for (int unsigned n = 0; n < FU_ARRAY; n++) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (!win_valid[n] && cand[n][i] && ((cand[n] & older[i]) == '0)) begin
          win_valid[n] = 1'b1;
          win_idx[n]   = IDX_W'(i);
          win_vec[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_valid_out <= '0;
      grant_idx_out1  <= '0;
      grant_idx_out2  <= '0;
      grant_idx_out3  <= '0;
      grant_vec_out   <= '0;
      lsu_cnt_q       <= '0;
    end else if (flush_in) begin
      grant_valid_out <= '0;
      grant_vec_out   <= '0;
      lsu_cnt_q       <= '0;
    end else begin
      grant_valid_out <= win_valid;
      grant_vec_out   <= win_vec;
      if (win_valid[0]) grant_idx_out1 <= win_idx[0];
      if (win_valid[1]) grant_idx_out2 <= win_idx[1];
      if (win_valid[LSU_FU]) grant_idx_out3 <= win_idx[LSU_FU];
      if (win_valid[LSU_FU]) begin
        lsu_cnt_q <= CNT_W'(LSU_LAT - 1);
      end else if (lsu_cnt_q != '0) begin
        lsu_cnt_q <= lsu_cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/issue_arbiter.md
ISSUE_ARBITER -- requirements
Module: issue_arbiter

Interface
REQ-001 The block SHALL have parameter RS_SIZE, default 16, number of issue queue entries.
REQ-002 The block SHALL have parameter FU_ARRAY, default 3, number of functional units (FU0 ALU, FU1 ALU, FU2 LSU).
REQ-003 The block SHALL have parameter LSU_LAT, default 3, minimum cycles between FU2 grants (>=1).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_valid_in  input  RS_SIZE  entry i valid with both operands ready.
REQ-008 req_fu_in  input  2*RS_SIZE  FU class of entry i in bits [2i+1:2i]; value 3 is illegal and never granted.
REQ-009 alloc_valid_in  input  1  an entry is written into the queue this cycle.
REQ-010 alloc_idx_in  input  4  index of the allocated entry.
REQ-011 fu_ready_from_FU_in  input  FU_ARRAY  FU n accepts an instruction.
REQ-012 flush_in  input  1  pipeline flush.
REQ-013 grant_valid_out  output  FU_ARRAY  registered; FU n receives an instruction this cycle.
REQ-014 grant_idx_out1/2/3  output  4 each  registered entry index for FU0/FU1/FU2.
REQ-015 grant_vec_out  output  RS_SIZE  registered one-hot-per-grant mask of entries issued; queue frees these.
REQ-016 fu_busy_out  output  FU_ARRAY  FU n is blocked by the internal busy counter (only bit 2 can be set).

Function
REQ-017 Eligibility: entry i SHALL be a candidate for FU n when req_valid_in[i], req_fu_in[i]==n, grant_vec_out[i]==0, fu_ready_from_FU_in[n]==1 and fu_busy_out[n]==0.
REQ-018 Selection: per FU, the oldest candidate per the age matrix SHALL win; at most one grant per FU per cycle; an entry SHALL never be granted to two FUs.
REQ-019 Latency: grants SHALL appear on outputs one cycle after the requesting inputs (registered outputs, no combinational input-to-output path).
REQ-020 Re-grant mask: an entry present in grant_vec_out SHALL be excluded from arbitration in that cycle, even if req_valid_in[i] is still 1.
REQ-021 Age matrix: RS_SIZE x RS_SIZE bits, age[i][j]=1 means i older than j; on alloc of k, row k SHALL clear and age[i][k] SHALL set for all i!=k.
REQ-022 Simultaneous alloc and arbitration SHALL use the matrix value before the update.
REQ-023 With no candidate for FU n, grant_valid_out[n]=0 and grant_idx for that FU SHALL hold its previous value.
REQ-024 LSU counter: on the edge asserting grant_valid_out[2], counter SHALL load LSU_LAT-1; it decrements to 0 each cycle; fu_busy_out[2]=(counter!=0).
REQ-025 Flush: on an edge with flush_in=1, grant_valid_out and grant_vec_out SHALL be 0, LSU counter SHALL be 0; age matrix SHALL be cleared.
REQ-026 Flush with alloc in the same cycle: flush SHALL win; the allocation is ignored by the age matrix.

Reset
REQ-027 While rst=1: grant_valid_out=0, grant_idx_out1/2/3=0, grant_vec_out=0, fu_busy_out=0, LSU counter=0, age matrix all 0.
REQ-028 Reset asserted mid-operation SHALL immediately clear all outputs without waiting for clk; first grant possible on the second edge after deassertion.

Configuration
REQ-029 Macro ISSUE_AGE_PRIORITY_EN defined: selection SHALL be oldest-first per REQ-018/REQ-021.
REQ-030 Macro ISSUE_AGE_PRIORITY_EN undefined: age matrix SHALL be omitted, alloc inputs ignored, and the lowest-index candidate SHALL win; all other behaviour unchanged.

Verification
REQ-031 Reset: assert rst mid-grant -> all outputs 0 asynchronously; after release, req_valid_in=16'h0001, req_fu=0, FU ready -> grant_valid_out=3'b001, grant_idx_out1=0 one cycle later.
REQ-032 Age: alloc entry 5 then entry 2, both ready for FU0 -> grant_idx_out1=5 first, then 2 (with macro); without macro -> 2 first.
REQ-033 Parallel: entries 1,3,7 ready for FU0,FU1,FU2 -> grant_valid_out=3'b111, idx 1/3/7, grant_vec_out=16'h008A in one cycle.
REQ-034 LSU spacing: entries 4,6 held ready for FU2, LSU_LAT=3 -> grants to 4 and 6 exactly three cycles apart; fu_busy_out[2] high for the two cycles between.
REQ-035 Backpressure/mask: fu_ready_from_FU_in=3'b110 with entry 0 ready for FU0 -> no FU0 grant; entry held valid one cycle after grant -> not re-granted.
REQ-036 Flush: flush_in with alloc and ready requests in the same cycle -> next cycle grant_valid_out=0, fu_busy_out=0, age matrix empty.
